// File: rtl/fare_meter_pkg.sv
// rtl/fare_meter_pkg.sv - shared trip-state codes, FSM encoding and BCD validity helper
package fare_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MOVE = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b11;
    localparam logic [1:0] ST_RSVD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FREE   = 2'b01,
        S_CHARGE = 2'b10
    } fsm_t;

    // Zero-extended inputs pass, so any width up to 16 digits can be checked.
    function automatic logic is_bcd(input logic [63:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// rtl/bcd_add_sat.sv - combinational digit-serial BCD adder clamping to all 9s on overflow
module bcd_add_sat #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                ovf
);

    logic [4*DIGITS-1:0] raw;
    logic [4:0]          digit;
    logic                carry;

    always_comb begin
        raw   = '0;
        digit = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
            if (digit > 5'd9) begin
                digit          = digit - 5'd10;
                carry          = 1'b1;
            end else begin
                carry          = 1'b0;
            end
            raw[4*i +: 4] = digit[3:0];
        end
    end

    assign ovf = carry;
    assign sum = carry ? {DIGITS{4'h9}} : raw;

endmodule

// File: rtl/fare_meter_bcd.sv
// rtl/fare_meter_bcd.sv - BCD taxi fare meter; `define NIGHT_RATE_EN adds the night port and night distance rate
module fare_meter_bcd
    import fare_meter_pkg::*;
#(
    parameter int                  DIGITS         = 5,
    parameter int                  DIST_DIV       = 10,
    parameter int                  TIME_DIV       = 600,
    parameter int                  FREE_UNITS     = 300,
    parameter logic [4*DIGITS-1:0] START_FARE     = 'h09000,
    parameter logic [4*DIGITS-1:0] DIST_INC       = 'h00024,
    parameter logic [4*DIGITS-1:0] TIME_INC       = 'h01000,
    parameter logic [4*DIGITS-1:0] DIST_INC_NIGHT = 'h00031
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          state,
`ifdef NIGHT_RATE_EN
    input  logic                night,
`endif
    output logic [4*DIGITS-1:0] fare,
    output logic [4*DIGITS-1:0] fare_locked,
    output logic                done,
    output logic                sat,
    output logic                active
);

    localparam int W   = 4 * DIGITS;
    localparam int DCW = (DIST_DIV > 1) ? $clog2(DIST_DIV) : 1;
    localparam int TCW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam int UCW = $clog2(FREE_UNITS + 1);

    if (!(is_bcd(64'(START_FARE)) && is_bcd(64'(DIST_INC)) && is_bcd(64'(TIME_INC)) &&
          is_bcd(64'(DIST_INC_NIGHT)) && DIST_DIV >= 1 && TIME_DIV >= 1 && FREE_UNITS >= 1 &&
          DIGITS >= 1 && DIGITS <= 16)) begin : g_bad_params
        $fatal(1, "fare_meter_bcd: invalid parameter set");
    end

    fsm_t           fsm;
    fsm_t           fsm_nxt;
    logic [DCW-1:0] dist_cnt;
    logic [TCW-1:0] time_cnt;
    logic [UCW-1:0] unit_cnt;

    logic           is_move;
    logic           is_wait;
    logic           is_idle;
    logic           dist_tick;
    logic           time_tick;
    logic           free_done;

    logic           trip_start;
    logic           trip_end;
    logic           add_en;
    logic           night_sel;
    logic [W-1:0]   inc;
    logic [W-1:0]   sum;
    logic           ovf;

    assign is_move   = (state == ST_MOVE);
    assign is_wait   = (state == ST_WAIT);
    assign is_idle   = (state == ST_IDLE);
    assign dist_tick = is_move && (dist_cnt == DCW'(DIST_DIV - 1));
    assign time_tick = is_wait && (time_cnt == TCW'(TIME_DIV - 1));
    assign free_done = dist_tick && (unit_cnt == UCW'(FREE_UNITS - 1));

`ifdef NIGHT_RATE_EN
    assign night_sel = night;
`else
    assign night_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE: begin
                if (is_move || is_wait) begin
                    fsm_nxt = S_FREE;
                end
            end
            S_FREE: begin
                if (is_idle) begin
                    fsm_nxt = S_IDLE;
                end else if (free_done) begin
                    fsm_nxt = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (is_idle) begin
                    fsm_nxt = S_IDLE;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // The tick that exhausts the free distance is itself free, so only S_CHARGE charges distance.
    always_comb begin
        trip_start = 1'b0;
        trip_end   = 1'b0;
        add_en     = 1'b0;
        inc        = TIME_INC;
        case (fsm)
            S_IDLE: begin
                trip_start = is_move || is_wait;
            end
            S_FREE: begin
                trip_end = is_idle;
                add_en   = time_tick;
            end
            S_CHARGE: begin
                trip_end = is_idle;
                add_en   = time_tick || dist_tick;
                if (dist_tick) begin
                    inc = night_sel ? DIST_INC_NIGHT : DIST_INC;
                end
            end
            default: begin
                trip_end = 1'b0;
            end
        endcase
    end

    // Counters keep running on the trip-start edge; only the fare update is suppressed there.
    always_ff @(posedge clk) begin
        if (rst || trip_end) begin
            dist_cnt <= '0;
            time_cnt <= '0;
            unit_cnt <= '0;
        end else begin
            if (is_move) begin
                dist_cnt <= dist_tick ? '0 : dist_cnt + 1'b1;
            end
            if (is_wait) begin
                time_cnt <= time_tick ? '0 : time_cnt + 1'b1;
            end
            if (fsm == S_FREE && dist_tick) begin
                unit_cnt <= unit_cnt + 1'b1;
            end
        end
    end

    bcd_add_sat #(
        .DIGITS(DIGITS)
    ) u_add (
        .a  (fare),
        .b  (inc),
        .sum(sum),
        .ovf(ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fare        <= '0;
            fare_locked <= '0;
            done        <= 1'b0;
            sat         <= 1'b0;
            active      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (trip_start) begin
                fare   <= START_FARE;
                sat    <= 1'b0;
                active <= 1'b1;
            end else if (trip_end) begin
                fare_locked <= fare;
                done        <= 1'b1;
                fare        <= '0;
                active      <= 1'b0;
            end else if (add_en) begin
                fare <= sum;
                if (ovf) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fare_meter_bcd.md
Name: fare_meter_bcd

Overview:
Parametrised BCD taxi fare meter. It is the successor to the fixed five-digit price meter.
- Accumulates a start fare, a per-distance-unit charge after a free distance, and a per-time-unit waiting charge.
- All digit count, divider, free-distance and rate values are generics.
- Sits between the trip controller (which supplies the state code) and the display/receipt logic (which consumes fare, fare_locked and done).

Parameters:
DIGITS, 5, number of BCD digits in the fare (fare width W = 4*DIGITS)
DIST_DIV, 10, clk cycles in MOVE per distance unit
TIME_DIV, 600, clk cycles in WAIT per time unit
FREE_UNITS, 300, distance units covered by the start fare before distance charging begins
START_FARE, 'h09000, BCD start fare loaded at trip start (W bits)
DIST_INC, 'h00024, BCD increment per charged distance unit
TIME_INC, 'h01000, BCD increment per time unit
DIST_INC_NIGHT, 'h00031, BCD night distance increment (used only with NIGHT_RATE_EN)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
state  in  2  trip state: 00 IDLE, 01 MOVE, 11 WAIT, 10 reserved
fare  out  W  running BCD fare
fare_locked  out  W  BCD fare captured at trip end
done  out  1  one-cycle pulse when fare_locked is updated
sat  out  1  fare has saturated at all-9s during the current trip
active  out  1  a trip is in progress
night  in  1  night-rate select (present only with NIGHT_RATE_EN)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: fare=0, fare_locked=0, done=0, sat=0, active=0; all counters 0; FSM in S_IDLE.
- FSM states:
  - S_IDLE: no trip.
  - S_FREE: trip in progress, within the free distance.
  - S_CHARGE: free distance used up; distance charging on.
- S_IDLE -> S_FREE on the first edge with state in {MOVE, WAIT}. On that edge: fare<=START_FARE, sat<=0, active<=1. No tick is applied on this edge.
- dist_cnt:
  - Counts only in MOVE; range 0..DIST_DIV-1.
  - dist_tick = (state==MOVE && dist_cnt==DIST_DIV-1); on that edge the counter wraps to 0.
- time_cnt:
  - Counts only in WAIT; range 0..TIME_DIV-1.
  - time_tick defined the same way.
- Both counters hold their value while in the other active state or in the reserved code.
- unit_cnt counts dist_ticks while in S_FREE. On the tick that makes unit_cnt reach FREE_UNITS, go to S_CHARGE; that tick itself is not charged.
- In S_CHARGE, each dist_tick adds DIST_INC to fare on the same edge.
- time_tick adds TIME_INC in both S_FREE and S_CHARGE.
- dist_tick and time_tick are mutually exclusive by construction, so at most one addition per cycle.
- Addition:
  - Digit-serial BCD carry chain, combinational, result registered the same cycle.
  - If the carry out of the top digit is 1: fare<=all 9s and sat<=1; further ticks leave fare at all 9s.
- Reserved code 10: counters, fare and FSM all hold; no trip end.
- Trip end, on the first edge with state==IDLE while not in S_IDLE:
  - fare_locked<=fare (value before this edge); done<=1 for exactly one cycle.
  - fare<=0, active<=0, counters<=0, unit_cnt<=0, FSM->S_IDLE.
  - sat holds until the next trip start.
- rst asserted mid-trip: everything returns to reset values. fare_locked is cleared and no done pulse is issued.
- Elaboration check: START_FARE, DIST_INC, TIME_INC and DIST_INC_NIGHT must be valid BCD (every nibble ≤9), and DIST_DIV, TIME_DIV, FREE_UNITS must each be ≥1. Any violation is a fatal elaboration error.

Optional Feature:
NIGHT_RATE_EN
- Defined: port night exists. A charged dist_tick adds DIST_INC_NIGHT when night==1 on that edge, and DIST_INC otherwise. The time rate is unchanged.
- Undefined: no night port; DIST_INC_NIGHT is ignored and distance charging always uses DIST_INC.

Decomposition:
- Package fare_meter_pkg holds:
  - state-code constants ST_IDLE, ST_MOVE, ST_WAIT, ST_RSVD;
  - the FSM state enum;
  - a function that checks a vector is valid BCD.
- Sub-module bcd_add_sat(DIGITS): combinational W-bit BCD adder with saturation. Outputs sum and ovf.

Test Plan:
Test overrides: DIGITS=5, DIST_DIV=2, TIME_DIV=4, FREE_UNITS=3; all other parameters at default.
- IDLE->MOVE for 10 cycles, then IDLE:
  - fare=09000 after the first edge;
  - 5 dist_ticks, the first 3 free;
  - fare=09048 before the end;
  - done pulse with fare_locked=09048, then fare=00000.
- MOVE 1 cycle, WAIT 8 cycles, IDLE: 2 time_ticks, giving fare_locked=11000; dist_cnt is held at 1 through WAIT.
- BCD carry: override START_FARE='h09978, MOVE for 10 cycles. The two charged ticks give 10002 then 10026, so fare=10026.
- Saturation: override START_FARE='h99990, MOVE for 10 cycles. fare=99999 and sat=1 after the first charged tick; fare holds 99999; fare_locked=99999.
- Reserved/reset:
  - state=10 for 5 cycles mid-trip: fare, counters and active frozen.
  - rst=1 mid-trip: all outputs 0 on the next edge and no done pulse.
- NIGHT_RATE_EN defined, night=1, MOVE for 10 cycles: fare=09062 before the end (2 charged ticks × 31).
